// File: rtl/multi_cycle_control.sv
// Main control FSM for a multi-cycle register/ALU/memory datapath.
// Controls decode from the registered state; FETCH and BRANCH also use MemReady/Zero.
module multi_cycle_control #(
    parameter int         COUNT_W  = 32,
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_J     = 6'h02,
    parameter logic [5:0] OP_ADDI  = 6'h08
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [5:0]         Op,
    input  logic               Zero,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemToReg,
    output logic               IRWrite,
    output logic [1:0]         PCSource,
    output logic [1:0]         ALUOp,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               RegWrite,
    output logic               RegDst,
    output logic [3:0]         State,
    output logic               Illegal,
    output logic [COUNT_W-1:0] InstrCount
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_EXEC      = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_HALT      = 4'd12
    } state_t;

    localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

    state_t             r_state;
    logic               r_illegal;
    logic [COUNT_W-1:0] r_count;

    // Retiring states bump the counter on the same edge that returns to FETCH.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
            r_count   <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (MemReady) r_state <= S_DECODE;
                end
                S_DECODE: begin
                    if (Op == OP_LW || Op == OP_SW) r_state <= S_MEM_ADDR;
                    else if (Op == OP_RTYPE)        r_state <= S_EXEC;
                    else if (Op == OP_BEQ)          r_state <= S_BRANCH;
                    else if (Op == OP_J)            r_state <= S_JUMP;
                    else if (Op == OP_ADDI)         r_state <= S_ADDI_EXEC;
                    else begin
                        r_state   <= S_HALT;
                        r_illegal <= 1'b1;
                    end
                end
                S_MEM_ADDR: begin
                    r_state <= (Op == OP_LW) ? S_MEM_RD : S_MEM_WR;
                end
                S_MEM_RD: begin
                    if (MemReady) r_state <= S_MEM_WB;
                end
                S_MEM_WR: begin
                    if (MemReady) begin
                        r_state <= S_FETCH;
                        r_count <= r_count + COUNT_ONE;
                    end
                end
                S_EXEC:      r_state <= S_R_WB;
                S_ADDI_EXEC: r_state <= S_ADDI_WB;
                S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
                    r_state <= S_FETCH;
                    r_count <= r_count + COUNT_ONE;
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        PCWrite  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemToReg = 1'b0;
        IRWrite  = 1'b0;
        PCSource = 2'b00;
        ALUOp    = 2'b00;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        RegWrite = 1'b0;
        RegDst   = 1'b0;
        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                MemToReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_R_WB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 2'b01;
                PCSource = 2'b01;
                PCWrite  = Zero;
            end
            S_JUMP: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
            end
            S_ADDI_WB: begin
                RegWrite = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign State      = r_state;
    assign Illegal    = r_illegal;
    assign InstrCount = r_count;

endmodule
